// File: rtl/memory_pkg.sv
// Shared sizing and nibble type for the 4-bit CPU datapath RAM and its neighbours.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package memory_pkg;

    localparam int MEM_ADDR_WIDTH = 8;
    localparam int MEM_DATA_WIDTH = 4;
    localparam int MEM_DEPTH      = 2 ** MEM_ADDR_WIDTH;

    typedef logic [MEM_DATA_WIDTH-1:0] nibble_t;

endpackage

// File: rtl/nibble_bus_driver.sv
// Tri-state driver joining the RAM's internal read/write paths to the shared data bus.
// Latency: combinational in both directions.
// Backpressure: none; the bus master must release the bus whenever oe is high.
module nibble_bus_driver #(
    parameter int WIDTH = 4
) (
    input  logic             oe,
    input  logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] data_in,
    inout  wire  [WIDTH-1:0] bus
);

    assign bus     = oe ? data_out : {WIDTH{1'bz}};
    assign data_in = bus;

endmodule

// File: rtl/memory_4bit_256nibble_core.sv
// 256 x 4-bit single-port RAM on a shared bidirectional bus, cleared by async reset.
// Latency: write commits on the rising clk edge; read is combinational (zero cycles).
// Backpressure: none; every write is accepted, every read is answered in the same cycle.
module memory_4bit_256nibble_core
    import memory_pkg::*;
#(
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = MEM_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] address,
    inout  wire  [DATA_WIDTH-1:0] data_bus,
    input  logic                  write_enable
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  oe;

    // Output enable falls back off during reset so the bus floats while the array clears.
    assign oe       = rst_n & ~write_enable;
    assign data_out = mem_q[address];

    nibble_bus_driver #(
        .WIDTH (DATA_WIDTH)
    ) u_bus_driver (
        .oe       (oe),
        .data_out (data_out),
        .data_in  (data_in),
        .bus      (data_bus)
    );

    always_comb begin
        mem_d = mem_q;
        if (write_enable) begin
            mem_d[address] = data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: tb/tb_memory_4bit_256nibble_core.sv
// Directed bench for the nibble RAM: an array model tracks every write and a
// per-cycle compare checks reads, alongside hand-computed literal expectations.
module tb_memory_4bit_256nibble_core;

    logic       clk;
    logic       rst_n;
    logic [7:0] address;
    logic       write_enable;
    logic       drv_en;
    logic [3:0] drv_dat;
    wire  [3:0] data_bus;

    int checks;
    int errors;

    logic [3:0] model [256];

    assign data_bus = drv_en ? drv_dat : 4'bz;

    memory_4bit_256nibble_core dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .address      (address),
        .data_bus     (data_bus),
        .write_enable (write_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a plain array, cleared on reset, written on each enabled edge.
    always @(negedge rst_n) begin
        for (int i = 0; i < 256; i++) model[i] = 4'h0;
    end

    always @(posedge clk) begin
        if (rst_n === 1'b1 && write_enable === 1'b1 && drv_en === 1'b1)
            model[address] = drv_dat;
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && write_enable === 1'b0)
            chk("cycle_read", data_bus, model[address]);
        else if (drv_en === 1'b1)
            chk("cycle_bus_no_contention", data_bus, drv_dat);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [3:0] d, input string nm);
        address      = a;
        drv_dat      = d;
        drv_en       = 1'b1;
        write_enable = 1'b1;
        #1 chk(nm, data_bus, d);
        next_cycle();
        write_enable = 1'b0;
        drv_en       = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] a, input logic [3:0] exp, input string nm);
        write_enable = 1'b0;
        drv_en       = 1'b0;
        address      = a;
        #1 chk(nm, data_bus, exp);
        next_cycle();
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        for (int i = 0; i < 256; i++) model[i] = 4'h0;
        rst_n        = 1'b0;
        address      = 8'h00;
        write_enable = 1'b0;
        drv_en       = 1'b0;
        drv_dat      = 4'h0;

        #12 rst_n = 1'b1;
        next_cycle();

        do_read(8'h00, 4'h0, "reset_read_00");
        do_read(8'h0A, 4'h0, "reset_read_0a");
        do_read(8'hFF, 4'h0, "reset_read_ff");

        do_write(8'h0A, 4'hA, "write_0a_bus");
        do_read(8'h0A, 4'hA, "read_0a");

        do_write(8'h00, 4'h5, "write_00_bus");
        do_write(8'hFF, 4'hC, "write_ff_bus");
        do_read(8'h01, 4'h0, "isolation_01");
        do_read(8'h00, 4'h5, "isolation_00");
        do_read(8'hFF, 4'hC, "isolation_ff");

        // Memory holds 5 here; a driving memory would corrupt the 9 on the bus.
        do_write(8'h00, 4'h9, "write_over_5_bus");
        do_read(8'h00, 4'h9, "read_00_after_rewrite");

        // write_enable held across two edges: last edge wins.
        address      = 8'h80;
        drv_dat      = 4'h3;
        drv_en       = 1'b1;
        write_enable = 1'b1;
        next_cycle();
        drv_dat = 4'hE;
        next_cycle();
        write_enable = 1'b0;
        drv_en       = 1'b0;
        #1 chk("overwrite_80", data_bus, 4'hE);
        next_cycle();

        // Address changes within one cycle, no clock edge in between.
        address = 8'h00;
        #1 chk("comb_00", data_bus, 4'h9);
        address = 8'hFF;
        #1 chk("comb_ff", data_bus, 4'hC);
        address = 8'h00;
        #1 chk("comb_00_again", data_bus, 4'h9);
        next_cycle();

        do_write(8'h10, 4'h7, "write_10_bus");
        do_read(8'h10, 4'h7, "read_10_before_reset");

        // Reset mid-write; an edge with write_enable high lands during reset.
        address      = 8'h10;
        drv_dat      = 4'hB;
        drv_en       = 1'b1;
        write_enable = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk("bus_released_in_reset", data_bus, 4'hB);
        next_cycle();
        write_enable = 1'b0;
        drv_en       = 1'b0;
        #1 rst_n = 1'b1;
        next_cycle();

        do_read(8'h10, 4'h0, "read_10_after_reset");
        do_read(8'h0A, 4'h0, "read_0a_after_reset");
        do_read(8'hFF, 4'h0, "read_ff_after_reset");

        do_write(8'h20, 4'h6, "write_20_bus");
        do_read(8'h20, 4'h6, "read_20_first_write");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
